// File: rtl/watch_mode_ctrl.sv
// Watch front-end: conditions raw buttons (sync, debounce, one-pulse) and owns the top-level mode.
// Routes qualified set/clear/aoff pulses, drives the time-set cursor and auto-returns to CLOCK when idle.
module watch_mode_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int IDLE_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode0,
  input  logic       mode1,
  input  logic       set,
  input  logic       clear,
  input  logic       aoff,
  input  logic       sw_run,
  output logic [1:0] mstate,
  output logic       set_p,
  output logic       clear_p,
  output logic       aoff_p,
  output logic       inc_p,
  output logic [1:0] field
);

  localparam int NB = 5;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int IW = $clog2(IDLE_TICKS + 1);

  localparam int B_MODE0 = 0;
  localparam int B_MODE1 = 1;
  localparam int B_SET   = 2;
  localparam int B_CLEAR = 3;
  localparam int B_AOFF  = 4;

  typedef enum logic [1:0] {
    MS_CLOCK = 2'b00,
    MS_ALARM = 2'b01,
    MS_SW    = 2'b10,
    MS_TSET  = 2'b11
  } mstate_e;

  // sw_run is status only: the stopwatch is exempt from timeout regardless of it.
  logic unused_sw_run;
  assign unused_sw_run = sw_run;

  logic [NB-1:0] raw;
  assign raw = {aoff, clear, set, mode1, mode0};

  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] deb_q, deb_d;
  logic [NB-1:0] press_q, press_d;
  logic [DW-1:0] cnt_q [NB];
  logic [DW-1:0] cnt_d [NB];

  mstate_e       state_q, state_d;
  logic [1:0]    field_q, field_d;
  logic          set_p_q, set_p_d;
  logic          clear_p_q, clear_p_d;
  logic          aoff_p_q, aoff_p_d;
  logic          inc_p_q, inc_p_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          mode_chg;

  // Debounce: the level flips on the DEB_CYCLES-th consecutive differing synced sample.
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
        cnt_d[i]   = '0;
        deb_d[i]   = sync2_q[i];
        press_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Mode FSM and pulse routing; mode1 takes priority and suppresses a coincident mode0.
  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    set_p_d   = 1'b0;
    clear_p_d = 1'b0;
    inc_p_d   = 1'b0;
    aoff_p_d  = press_q[B_AOFF];
    idle_d    = idle_q;

    if (press_q[B_MODE1]) begin
      if (state_q == MS_CLOCK) begin
        state_d = MS_TSET;
        field_d = 2'b00;
      end else if (state_q == MS_TSET) begin
        state_d = MS_CLOCK;
      end
    end else if (press_q[B_MODE0]) begin
      case (state_q)
        MS_CLOCK: state_d = MS_ALARM;
        MS_ALARM: state_d = MS_SW;
        MS_SW:    state_d = MS_CLOCK;
        default:  state_d = state_q;
      endcase
    end

    mode_chg = (state_d != state_q);

    if (!mode_chg) begin
      if (press_q[B_SET]) begin
        if (state_q == MS_TSET) field_d = (field_q == 2'b10) ? 2'b00 : field_q + 2'b01;
        else                    set_p_d = 1'b1;
      end
      if (press_q[B_CLEAR]) begin
        if (state_q == MS_TSET) inc_p_d   = 1'b1;
        else                    clear_p_d = 1'b1;
      end
    end

    // Any press beats a pending timeout on the same edge.
    if ((|press_q) || mode_chg) begin
      idle_d = '0;
    end else if (state_q == MS_CLOCK || state_q == MS_SW) begin
      idle_d = '0;
    end else if (idle_q == IW'(IDLE_TICKS)) begin
      state_d = MS_CLOCK;
      idle_d  = '0;
    end else if (tick) begin
      idle_d = idle_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MS_CLOCK;
      field_q   <= 2'b00;
      set_p_q   <= 1'b0;
      clear_p_q <= 1'b0;
      aoff_p_q  <= 1'b0;
      inc_p_q   <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      set_p_q   <= set_p_d;
      clear_p_q <= clear_p_d;
      aoff_p_q  <= aoff_p_d;
      inc_p_q   <= inc_p_d;
      idle_q    <= idle_d;
    end
  end

  assign mstate  = state_q;
  assign field   = field_q;
  assign set_p   = set_p_q;
  assign clear_p = clear_p_q;
  assign aoff_p  = aoff_p_q;
  assign inc_p   = inc_p_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed scenarios plus randomized press/tick sequences against an event-level model.
module tb_watch_mode_ctrl;

  localparam int DEB  = 4;
  localparam int IDLE = 3;

  logic clk = 1'b0;
  logic reset, tick, mode0, mode1, set, clear, aoff, sw_run;
  logic [1:0] mstate, field;
  logic set_p, clear_p, aoff_p, inc_p;

  watch_mode_ctrl #(.DEB_CYCLES(DEB), .IDLE_TICKS(IDLE)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .mode0(mode0), .mode1(mode1), .set(set), .clear(clear), .aoff(aoff),
    .sw_run(sw_run),
    .mstate(mstate), .set_p(set_p), .clear_p(clear_p), .aoff_p(aoff_p),
    .inc_p(inc_p), .field(field)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // High-cycle counters for each pulse output, sampled on the falling edge.
  int c_set = 0, c_clear = 0, c_aoff = 0, c_inc = 0;
  always @(negedge clk) begin
    if (set_p)   c_set++;
    if (clear_p) c_clear++;
    if (aoff_p)  c_aoff++;
    if (inc_p)   c_inc++;
  end

  // Event-level reference model: mode 0 CLOCK, 1 ALARM, 2 STOPWATCH, 3 TSET.
  int m_st = 0, m_field = 0, m_idle = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_buttons(input logic [4:0] b);
    {aoff, clear, set, mode1, mode0} = b;
  endtask

  task automatic model_press(input logic [4:0] b, output int es, output int ec,
                             output int ei, output int ea);
    int prev;
    prev = m_st;
    es = 0; ec = 0; ei = 0;
    if (b[1]) begin
      if (m_st == 0) begin m_st = 3; m_field = 0; end
      else if (m_st == 3) m_st = 0;
    end else if (b[0] && m_st != 3) begin
      m_st = (m_st + 1) % 3;
    end
    if (m_st == prev) begin
      if (b[2]) begin
        if (prev == 3) m_field = (m_field + 1) % 3;
        else es = 1;
      end
      if (b[3]) begin
        if (prev == 3) ei = 1;
        else ec = 1;
      end
    end
    ea = b[4] ? 1 : 0;
    if (b != 5'b0) m_idle = 0;
  endtask

  task automatic model_tick();
    if (m_st == 1 || m_st == 3) begin
      m_idle++;
      if (m_idle == IDLE) begin
        m_st = 0;
        m_idle = 0;
      end
    end
  endtask

  // Hold a set of buttons together, release, let the debouncer settle, then check.
  task automatic press_step(input logic [4:0] b, input int hold, input bit glitch, input string nm);
    int s0, c0, a0, i0, es, ec, ei, ea;
    s0 = c_set; c0 = c_clear; a0 = c_aoff; i0 = c_inc;
    drive_buttons(b);
    cyc(hold);
    drive_buttons(5'b0);
    cyc(DEB + 8);
    if (glitch) begin es = 0; ec = 0; ei = 0; ea = 0; end
    else model_press(b, es, ec, ei, ea);
    n_chk++;
    if (mstate !== 2'(m_st)) $display("FAIL %s mstate got %0d want %0d", nm, mstate, m_st);
    else n_pass++;
    n_chk++;
    if (field !== 2'(m_field)) $display("FAIL %s field got %0d want %0d", nm, field, m_field);
    else n_pass++;
    n_chk++;
    if (c_set - s0 != es) $display("FAIL %s set_p cycles got %0d want %0d", nm, c_set - s0, es);
    else n_pass++;
    n_chk++;
    if (c_clear - c0 != ec) $display("FAIL %s clear_p cycles got %0d want %0d", nm, c_clear - c0, ec);
    else n_pass++;
    n_chk++;
    if (c_inc - i0 != ei) $display("FAIL %s inc_p cycles got %0d want %0d", nm, c_inc - i0, ei);
    else n_pass++;
    n_chk++;
    if (c_aoff - a0 != ea) $display("FAIL %s aoff_p cycles got %0d want %0d", nm, c_aoff - a0, ea);
    else n_pass++;
  endtask

  task automatic tick_step(input int k, input string nm);
    for (int i = 0; i < k; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(2);
      model_tick();
    end
    cyc(1);
    n_chk++;
    if (mstate !== 2'(m_st)) $display("FAIL %s mstate got %0d want %0d", nm, mstate, m_st);
    else n_pass++;
    n_chk++;
    if (field !== 2'(m_field)) $display("FAIL %s field got %0d want %0d", nm, field, m_field);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; sw_run = 1'b0;
    drive_buttons(5'b0);
    cyc(3);
    n_chk++;
    if ({mstate, field, set_p, clear_p, aoff_p, inc_p} !== 8'h00)
      $display("FAIL reset outputs got %b want 00000000", {mstate, field, set_p, clear_p, aoff_p, inc_p});
    else n_pass++;
    reset = 1'b0;
    m_st = 0; m_field = 0; m_idle = 0;
    cyc(2);
    n_chk++;
    if (mstate !== 2'b00) $display("FAIL reset_release mstate got %0d want 0", mstate);
    else n_pass++;
  endtask

  task automatic test_glitch();
    press_step(5'b00001, DEB - 1, 1'b1, "glitch_mode0");
    n_chk++;
    if (mstate !== 2'b00) $display("FAIL glitch_const mstate got %0d want 0", mstate);
    else n_pass++;
  endtask

  task automatic test_latency();
    int changes;
    logic [1:0] last;
    mode0 = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (mstate !== 2'b00) $display("FAIL latency_edge6 mstate got %0d want 0", mstate);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (mstate !== 2'b01) $display("FAIL latency_edge7 mstate got %0d want 1", mstate);
    else n_pass++;
    changes = 0;
    last = mstate;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (mstate !== last) changes++;
      last = mstate;
    end
    n_chk++;
    if (changes != 0) $display("FAIL latency_hold extra mstate changes got %0d want 0", changes);
    else n_pass++;
    @(posedge clk); #1;
    mode0 = 1'b0;
    m_st = 1; m_idle = 0;
    cyc(DEB + 8);
  endtask

  task automatic test_mode_cycle();
    press_step(5'b00001, DEB + 2, 1'b0, "mode0_to_sw");
    press_step(5'b00001, DEB + 2, 1'b0, "mode0_to_clock");
    n_chk++;
    if (mstate !== 2'b00) $display("FAIL mode_cycle_const mstate got %0d want 0", mstate);
    else n_pass++;
    press_step(5'b00011, DEB + 3, 1'b0, "mode1_mode0_simul");
    n_chk++;
    if ({mstate, field} !== 4'b1100) $display("FAIL simul_const mstate/field got %b want 1100", {mstate, field});
    else n_pass++;
  endtask

  task automatic test_tset();
    press_step(5'b00100, DEB + 1, 1'b0, "tset_set1");
    press_step(5'b00100, DEB + 4, 1'b0, "tset_set2");
    press_step(5'b00100, DEB + 2, 1'b0, "tset_set3");
    n_chk++;
    if (field !== 2'b00) $display("FAIL tset_wrap field got %0d want 0", field);
    else n_pass++;
    press_step(5'b01000, DEB + 2, 1'b0, "tset_clear1");
    press_step(5'b01000, DEB + 5, 1'b0, "tset_clear2");
  endtask

  task automatic test_idle();
    press_step(5'b00010, DEB + 2, 1'b0, "leave_tset");
    press_step(5'b00001, DEB + 2, 1'b0, "enter_alarm");
    tick_step(2, "alarm_ticks2");
    press_step(5'b00100, DEB + 2, 1'b0, "alarm_set");
    tick_step(2, "alarm_ticks4");
    n_chk++;
    if (mstate !== 2'b01) $display("FAIL idle_restart mstate got %0d want 1", mstate);
    else n_pass++;
    tick_step(1, "alarm_timeout");
    n_chk++;
    if (mstate !== 2'b00) $display("FAIL idle_timeout mstate got %0d want 0", mstate);
    else n_pass++;
    press_step(5'b00001, DEB + 2, 1'b0, "to_alarm");
    press_step(5'b00001, DEB + 2, 1'b0, "to_sw");
    sw_run = 1'b1;
    tick_step(10, "sw_ticks");
    n_chk++;
    if (mstate !== 2'b10) $display("FAIL sw_no_timeout mstate got %0d want 2", mstate);
    else n_pass++;
    press_step(5'b00001, DEB + 2, 1'b0, "sw_leave_running");
    sw_run = 1'b0;
  endtask

  task automatic test_reset_midpress();
    int c0, i0;
    press_step(5'b00010, DEB + 2, 1'b0, "enter_tset_again");
    clear = 1'b1;
    cyc(DEB + 6);
    reset = 1'b1;
    cyc(2);
    n_chk++;
    if ({mstate, field, set_p, clear_p, aoff_p, inc_p} !== 8'h00)
      $display("FAIL reset_midpress outputs got %b want 00000000", {mstate, field, set_p, clear_p, aoff_p, inc_p});
    else n_pass++;
    c0 = c_clear; i0 = c_inc;
    reset = 1'b0;
    m_st = 0; m_field = 0; m_idle = 0;
    cyc(DEB + 8);
    clear = 1'b0;
    cyc(DEB + 8);
    n_chk++;
    if (c_clear - c0 != 1) $display("FAIL reset_repress clear_p cycles got %0d want 1", c_clear - c0);
    else n_pass++;
    n_chk++;
    if (c_inc - i0 != 0) $display("FAIL reset_repress inc_p cycles got %0d want 0", c_inc - i0);
    else n_pass++;
  endtask

  task automatic test_random();
    int kind;
    logic [4:0] b;
    for (int it = 0; it < 60; it++) begin
      sw_run = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        b = 5'($urandom_range(1, 31));
        press_step(b, $urandom_range(DEB, DEB + 6), 1'b0, "rand_press");
      end else if (kind == 7) begin
        b = 5'($urandom_range(1, 31));
        press_step(b, $urandom_range(1, DEB - 1), 1'b1, "rand_glitch");
      end else begin
        tick_step($urandom_range(1, 4), "rand_ticks");
      end
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive presses with only the minimum settle gap in between.
    press_step(5'b10100, DEB, 1'b0, "b2b_aoff_set");
    press_step(5'b11000, DEB, 1'b0, "b2b_aoff_clear");
    press_step(5'b00010, DEB, 1'b0, "b2b_mode1");
    press_step(5'b11100, DEB, 1'b0, "b2b_tset_combo");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; sw_run = 1'b0;
    mode0 = 1'b0; mode1 = 1'b0; set = 1'b0; clear = 1'b0; aoff = 1'b0;
    cyc(1);
    test_reset();
    test_glitch();
    test_latency();
    test_mode_cycle();
    test_tset();
    test_idle();
    test_reset_midpress();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
Front-end controller for the digital watch. Conditions the raw push-buttons (synchronise, debounce, one-pulse) and owns the top-level mode state `mstate`. It routes qualified `set`/`clear`/`aoff` pulses to the clock, alarm and stopwatch datapaths, and drives the time-set field cursor. It returns to clock mode after inactivity, except in stopwatch mode.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles (after sync) needed to accept a button level change; must be >=1
IDLE_TICKS, 30, `tick` pulses without any accepted press before ALARM/TSET auto-return to CLOCK; must be >=1

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high; clears all state
tick  input  1  1 Hz single-cycle enable
mode0  input  1  raw button: cycle modes
mode1  input  1  raw button: enter/leave time-set
set  input  1  raw button
clear  input  1  raw button
aoff  input  1  raw button: alarm off
sw_run  input  1  stopwatch running flag (ST of stopwatch)
mstate  output  2  00 CLOCK, 01 ALARM, 10 STOPWATCH, 11 TSET
set_p  output  1  qualified set pulse
clear_p  output  1  qualified clear pulse
aoff_p  output  1  alarm-off pulse
inc_p  output  1  increment selected field (TSET only)
field  output  2  TSET cursor: 00 hour, 01 min, 10 sec

Behaviour:
- Reset (sync): `mstate`=00, `field`=00, every pulse output 0, sync FFs 0, debounced levels 0, debounce and idle counters 0.
- Per button, stage 1: two-FF synchroniser.
- Per button, stage 2: debouncer.
  - A counter increments each cycle the synced value differs from the debounced level; it clears whenever they match.
  - When the count reaches DEB_CYCLES, the debounced level takes the synced value and the counter clears.
- Per button, stage 3: edge pulse.
  - A raw press held steady produces one internal press pulse, registered DEB_CYCLES+2 edges after the first edge sampling it high.
  - The pulse is exactly 1 cycle wide; no pulse on release.
  - Glitches shorter than DEB_CYCLES cycles produce nothing.
- Output pulses are registered 1 cycle after the internal press pulse. `mstate`/`field` updates occur on that same edge.
- Mode FSM on `mode0` press: CLOCK->ALARM->STOPWATCH->CLOCK. In TSET, `mode0` is ignored.
- Mode FSM on `mode1` press:
  - CLOCK->TSET, with `field` set to 00.
  - TSET->CLOCK.
  - Ignored in ALARM and STOPWATCH.
- Simultaneous `mode0`+`mode1` press pulses in the same cycle: `mode1` wins; `mode0` is dropped.
- A mode change cycle emits no `set_p`/`clear_p`/`inc_p`, even if those presses coincide; they are dropped, not deferred.
- `set` press:
  - In CLOCK/ALARM/STOPWATCH: `set_p`=1.
  - In TSET: `field` advances 00->01->10->00 and `set_p` stays 0.
- `clear` press:
  - In CLOCK/ALARM/STOPWATCH: `clear_p`=1.
  - In TSET: `inc_p`=1 and `clear_p` stays 0.
- `aoff` press: `aoff_p`=1 in every mode, including mode-change cycles.
- Downstream datapaths gate `set_p`/`clear_p` with `mstate`. The controller does not decode per-mode enables beyond the TSET remap above.
- Idle counter (width sized for IDLE_TICKS):
  - Clears on any accepted press of any button, and on every `mstate` change.
  - Increments on `tick` only while `mstate` is ALARM or TSET.
  - Held at 0 in CLOCK and STOPWATCH.
- Auto-return: when the idle count reaches IDLE_TICKS, `mstate` goes to CLOCK on the next edge and the counter clears.
  - If a press and the terminal `tick` coincide, the press wins and there is no timeout.
  - A timeout from TSET leaves `field` unchanged, but it is reinitialised on the next TSET entry.
- `sw_run` is status only:
  - STOPWATCH never times out, whether `sw_run` is 0 or 1.
  - Leaving STOPWATCH via `mode0` is allowed while `sw_run`=1; the stopwatch keeps running.
- Reset mid-press: debounced levels clear. A button still held after reset deasserts is re-debounced and produces one press pulse.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- DEB_CYCLES=4, `mode0` held 20 cycles from CLOCK -> exactly one internal pulse; `mstate`=01 after edge 7 counted from the first high sample; no further change.
- `mode0` glitch high for 3 cycles -> no pulse; `mstate` stays 00.
- Three `mode0` presses -> `mstate` 00->01->10->00. Then `mode1`+`mode0` pressed simultaneously from CLOCK -> `mstate`=11, `field`=00.
- In TSET: `set` x3 -> `field` 01,10,00; `set_p` never high. `clear` x2 -> two single-cycle `inc_p`; `clear_p`=0.
- IDLE_TICKS=3 in ALARM: 3 `tick` pulses -> `mstate`=00. With a `set` press between tick 2 and tick 3, 3 further ticks are needed. In STOPWATCH with `sw_run`=1, 10 ticks -> still 10.
- `reset` asserted while in TSET with a `clear` held -> all outputs 0 and `mstate`=00. With `clear` still held after release -> one `clear_p` pulse after debounce.
